// File: rtl/seq_alu.sv
`timescale 1ns/1ps
// Execute-stage ALU: single-cycle base ops, iterative RV32M multiply/divide/remainder.
// Latency: base op result registered at the accept edge; M ops take WIDTH further edges (fixed, incl. special cases).
// Backpressure: result/out_valid hold while out_ready is low; in_ready is high only in IDLE.
//
// Ports: clk/rst_n (async active-low), flush (sync abort), in_valid/in_ready + op/a/b in,
//        out_valid/out_ready + result out.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         mop_q;      // M-op selector of the in-flight operation
    logic [WIDTH-1:0]   a_q;        // original dividend, returned by REM/REMU on divide by zero
    logic [WIDTH-1:0]   acc;        // product high half / partial remainder
    logic [WIDTH-1:0]   mq;         // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0]   dvs;        // multiplicand magnitude / divisor magnitude
    logic [SHW-1:0]     cnt;
    logic               neg_q;      // negate product or quotient at the end
    logic               neg_r;      // negate remainder (dividend was negative)
    logic               bzero_q;
    logic [WIDTH-1:0]   result_q;

    logic               accept;
    logic [WIDTH-1:0]   base_res;
    logic               a_sgn, b_sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     msum, shifted, diff;
    logic               ge;
    logic [WIDTH-1:0]   step_acc, step_mq;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo, rem, fix_res;

    assign accept    = (state == IDLE) && in_valid && !flush;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;

    // Base operations, evaluated straight from the presented operands.
    always_comb begin
        base_res = '0;
        case (op[3:0])
            4'd0:    base_res = a + b;
            4'd1:    base_res = a - b;
            4'd2:    base_res = a & b;
            4'd3:    base_res = a | b;
            4'd4:    base_res = a ^ b;
            4'd5:    base_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd6:    base_res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd7:    base_res = a << b[SHW-1:0];
            4'd8:    base_res = $signed(a) >>> b[SHW-1:0];
            4'd9:    base_res = a >> b[SHW-1:0];
            4'd10:   base_res = b;
            default: base_res = '0;
        endcase
    end

    // Operand signs: A is signed for MULH/MULHSU/DIV/REM, B for MULH/DIV/REM.
    always_comb begin
        a_sgn = a[WIDTH-1] && (op[2:0] == 3'd1 || op[2:0] == 3'd2 ||
                               op[2:0] == 3'd4 || op[2:0] == 3'd6);
        b_sgn = b[WIDTH-1] && (op[2:0] == 3'd1 || op[2:0] == 3'd4 || op[2:0] == 3'd6);
        a_mag = a_sgn ? -a : a;
        b_mag = b_sgn ? -b : b;
    end

    // One iteration: shift-add multiply or restoring subtract-shift divide.
    always_comb begin
        step_acc = acc;
        step_mq  = mq;
        msum     = {1'b0, acc} + (mq[0] ? {1'b0, dvs} : '0);
        shifted  = {acc, mq[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        ge       = (shifted >= {1'b0, dvs});
        if (mop_q[2]) begin
            step_acc = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            step_mq  = {mq[WIDTH-2:0], ge};
        end else begin
            step_acc = msum[WIDTH:1];
            step_mq  = {msum[0], mq[WIDTH-1:1]};
        end
    end

    // Sign fix-up and special cases, applied to the output of the final iteration.
    // Signed overflow (most-negative / -1) falls out of the magnitude arithmetic.
    always_comb begin
        prod    = {step_acc, step_mq};
        prod_s  = neg_q ? -prod : prod;
        quo     = neg_q ? -step_mq : step_mq;
        rem     = neg_r ? -step_acc : step_acc;
        fix_res = '0;
        case (mop_q)
            3'd0:                fix_res = prod_s[WIDTH-1:0];
            3'd1, 3'd2, 3'd3:    fix_res = prod_s[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:          fix_res = bzero_q ? '1 : quo;
            default:             fix_res = bzero_q ? a_q : rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = op[4] ? BUSY : DONE;
            BUSY:    if (cnt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mop_q    <= '0;
            a_q      <= '0;
            acc      <= '0;
            mq       <= '0;
            dvs      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            bzero_q  <= 1'b0;
            result_q <= '0;
        end else if (!flush) begin
            if (accept) begin
                mop_q <= op[2:0];
                if (!op[4]) begin
                    result_q <= base_res;
                end else begin
                    a_q     <= a;
                    acc     <= '0;
                    // Multiply iterates over B's bits; divide shifts A's bits into the remainder.
                    mq      <= op[2] ? a_mag : b_mag;
                    dvs     <= op[2] ? b_mag : a_mag;
                    cnt     <= SHW'(WIDTH - 1);
                    neg_q   <= a_sgn ^ b_sgn;
                    neg_r   <= a_sgn;
                    bzero_q <= (b == '0);
                end
            end else if (state == BUSY) begin
                acc <= step_acc;
                mq  <= step_mq;
                if (cnt == '0) result_q <= fix_res;
                else           cnt      <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
// Directed bench for seq_alu (WIDTH=32): base ops, M ops, latency, backpressure, flush, reset.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Every check is an immediate assertion that counts passes and reports failures.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, then wait for out_valid; latency counts edges from the accept edge.
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int exp_lat, input logic [31:0] exp, input string tag);
        int lat;
        chk({tag, ":in_ready"}, {31'd0, in_ready}, 32'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        step();
        // Scramble inputs after acceptance; the in-flight operation must not notice.
        in_valid = 1'b0; op = 5'd0; a = ~x; b = ~y;
        lat = 1;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        chk({tag, ":lat"}, lat, exp_lat);
        chk({tag, ":res"}, result, exp);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ":back_to_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        logic seen;

        // Reset state, asserted and after release.
        #2;
        chk("rst:in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst:out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst:result",    result,             32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst:out_valid", {31'd0, out_valid}, 32'd0);

        // Base operations.
        issue(5'd0,  32'hFFFF_FFFF, 32'd2,          1, 32'h0000_0001, "add_wrap");  consume("add_wrap");
        issue(5'd1,  32'd3,         32'd5,          1, 32'hFFFF_FFFE, "sub");       consume("sub");
        issue(5'd2,  32'hF0F0_1234, 32'h0FF0_FF00,  1, 32'h00F0_1200, "and");       consume("and");
        issue(5'd3,  32'hF000_0001, 32'h0000_0F00,  1, 32'hF000_0F01, "or");        consume("or");
        issue(5'd4,  32'hAAAA_5555, 32'hFFFF_0000,  1, 32'h5555_5555, "xor");       consume("xor");
        issue(5'd5,  32'h8000_0000, 32'd1,          1, 32'd1,         "slt");       consume("slt");
        issue(5'd6,  32'h8000_0000, 32'd1,          1, 32'd0,         "sltu");      consume("sltu");
        issue(5'd7,  32'h0000_0081, 32'h0000_0104,  1, 32'h0000_0810, "sll");       consume("sll");
        issue(5'd8,  32'h8000_00F0, 32'h24,         1, 32'hF800_000F, "sra");       consume("sra");
        issue(5'd9,  32'h8000_00F0, 32'h24,         1, 32'h0800_000F, "srl");       consume("srl");
        issue(5'd10, 32'h1111_1111, 32'hCAFE_BABE,  1, 32'hCAFE_BABE, "copy_b");    consume("copy_b");
        issue(5'd13, 32'h1111_1111, 32'h2222_2222,  1, 32'd0,         "op13_zero"); consume("op13_zero");

        // Multiply.
        issue(5'd16, 32'hFFFF_FFFE, 32'd3, 33, 32'hFFFF_FFFA, "mul");    consume("mul");
        issue(5'd17, 32'hFFFF_FFFE, 32'd3, 33, 32'hFFFF_FFFF, "mulh");   consume("mulh");
        issue(5'd18, 32'hFFFF_FFFE, 32'd3, 33, 32'hFFFF_FFFF, "mulhsu"); consume("mulhsu");
        issue(5'd19, 32'hFFFF_FFFE, 32'd3, 33, 32'h0000_0002, "mulhu");  consume("mulhu");
        issue(5'd17, 32'h4000_0000, 32'h0000_0010, 33, 32'h0000_0004, "mulh_pos"); consume("mulh_pos");

        // Divide / remainder, including special cases.
        issue(5'd20, 32'hFFFF_FFF9, 32'd2,          33, 32'hFFFF_FFFD, "div");        consume("div");
        issue(5'd22, 32'hFFFF_FFF9, 32'd2,          33, 32'hFFFF_FFFF, "rem");        consume("rem");
        issue(5'd21, 32'd100,       32'd7,          33, 32'd14,        "divu");       consume("divu");
        issue(5'd23, 32'd100,       32'd7,          33, 32'd2,         "remu");       consume("remu");
        issue(5'd21, 32'd5,         32'd0,          33, 32'hFFFF_FFFF, "divu_by0");   consume("divu_by0");
        issue(5'd20, 32'hFFFF_FFF9, 32'd0,          33, 32'hFFFF_FFFF, "div_by0");    consume("div_by0");
        issue(5'd22, 32'hFFFF_FFF9, 32'd0,          33, 32'hFFFF_FFF9, "rem_by0");    consume("rem_by0");
        issue(5'd23, 32'd5,         32'd0,          33, 32'd5,         "remu_by0");   consume("remu_by0");
        issue(5'd20, 32'h8000_0000, 32'hFFFF_FFFF,  33, 32'h8000_0000, "div_ovf");    consume("div_ovf");
        issue(5'd22, 32'h8000_0000, 32'hFFFF_FFFF,  33, 32'd0,         "rem_ovf");    consume("rem_ovf");

        // Backpressure: result held for five cycles with out_ready low.
        issue(5'd0, 32'd40, 32'd2, 1, 32'd42, "bp_add");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp:out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp:result",    result,             32'd42);
            chk("bp:in_ready",  {31'd0, in_ready},  32'd0);
        end
        consume("bp");

        // Flush at BUSY cycle 10 of a DIV: back to IDLE, no result, result register retained.
        op = 5'd20; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) step();
        chk("flush:busy_before", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush:in_ready",  {31'd0, in_ready},  32'd1);
        chk("flush:out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush:result_kept", result, 32'd42);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("flush:no_output", {31'd0, seen}, 32'd0);

        // Flush coinciding with in_valid in IDLE drops the input.
        op = 5'd0; a = 32'd5; b = 32'd6; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_in:in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        chk("flush_in:dropped", {31'd0, seen}, 32'd0);
        chk("flush_in:result_kept", result, 32'd42);

        // Asynchronous reset mid-BUSY.
        op = 5'd16; a = 32'd9; b = 32'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("arst:busy_before", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst:in_ready",  {31'd0, in_ready},  32'd1);
        chk("arst:out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst:result",    result,             32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        chk("arst:no_output", {31'd0, seen}, 32'd0);
        issue(5'd0, 32'd1, 32'd1, 1, 32'd2, "add_after_rst"); consume("add_after_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
